lut_func_unit: RTL and testbench

- Parametrised, clocked successor to the team's fixed decoder-plus-mux 4-input function circuit.
- Evaluates an arbitrary IN_W-input Boolean function held in a runtime-loadable truth table; output is registered with a valid flag.
- The truth table is loaded in LOAD_W-bit beats over a valid/ready config port and committed atomically.
- Sits between the switch/input logic and the display/output stage wherever a reconfigurable combinational function is needed.

---
 rtl/lut_func_unit.sv | 73 +++++++
 tb/tb_lut_func_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/lut_func_unit.sv
// lut_func_unit: IN_W-input Boolean function from a runtime-loadable truth table, registered result.
// Build option LUT_SHADOW_EN: keep evaluating from the committed table while a new one loads.
module lut_func_unit #(
  parameter int IN_W = 4,
  parameter int LOAD_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic              cfg_valid,
  input  logic [LOAD_W-1:0] cfg_data,
  output logic              cfg_ready,
  output logic              cfg_done,
  output logic              busy,
  input  logic              in_valid,
  input  logic [IN_W-1:0]   x,
  output logic              in_ready,
  output logic              out_valid,
  output logic              f
);
  localparam int TBL = 1 << IN_W;
  localparam int BEATS = TBL / LOAD_W;
  localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
  typedef enum logic {RUN, LOAD} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TBL-1:0] stg_q, stg_d, tbl_q, tbl_d, stg_w;
  logic done_q, done_d, ov_q, ov_d, f_q, f_d, beat, last, acc;
  assign cfg_ready = state_q == LOAD;
  assign busy = cfg_ready;
  assign cfg_done = done_q;
  assign out_valid = ov_q;
  assign f = f_q;
`ifdef LUT_SHADOW_EN
  assign in_ready = 1'b1;
`else
  assign in_ready = state_q == RUN;
`endif
  // a restart in the same cycle swallows any beat presented with it
  assign beat = cfg_ready & cfg_valid & ~cfg_start;
  assign last = beat & (cnt_q == CW'(BEATS - 1));
  assign acc = in_valid & in_ready;
  always_comb begin
    stg_w = stg_q;
    stg_w[int'(cnt_q)*LOAD_W +: LOAD_W] = cfg_data;
    state_d = cfg_start ? LOAD : last ? RUN : state_q;
    cnt_d = cfg_start ? '0 : beat ? cnt_q + 1'b1 : cnt_q;
    stg_d = cfg_start ? '0 : beat ? stg_w : stg_q;
    tbl_d = last ? stg_w : tbl_q;
    done_d = last;
    ov_d = acc;
    f_d = acc ? tbl_q[x] : f_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q <= '0;
      stg_q <= '0;
      tbl_q <= '0;
      done_q <= 1'b0;
      ov_q <= 1'b0;
      f_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      stg_q <= stg_d;
      tbl_q <= tbl_d;
      done_q <= done_d;
      ov_q <= ov_d;
      f_q <= f_d;
    end
  end
endmodule

// File: tb/tb_lut_func_unit.sv
// tb_lut_func_unit: directed table-driven checks of lut_func_unit with IN_W=4, LOAD_W=4.
module tb_lut_func_unit;
  logic clk = 0, rst = 0, cfg_start = 0, cfg_valid = 0, in_valid = 0;
  logic [3:0] cfg_data = 0, x = 0;
  logic cfg_ready, cfg_done, busy, in_ready, out_valid, f;
  int checks = 0, errors = 0, dones = 0;
  typedef struct {logic [3:0] x; logic f;} vec_t;
  vec_t vt[7];

  lut_func_unit #(.IN_W(4), .LOAD_W(4)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
    .cfg_data(cfg_data), .cfg_ready(cfg_ready), .cfg_done(cfg_done), .busy(busy),
    .in_valid(in_valid), .x(x), .in_ready(in_ready), .out_valid(out_valid), .f(f)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (cfg_done) dones++;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask

  task automatic do_reset;
    rst = 1; cfg_start = 0; cfg_valid = 0; in_valid = 0;
    #2;
    rst = 0;
  endtask

  task automatic eval(input logic [3:0] xv, input logic ef, input string n);
    x = xv; in_valid = 1;
    tick;
    in_valid = 0;
    chk({n, "_ov"}, out_valid, 1);
    chk({n, "_f"}, f, ef);
  endtask

  task automatic load(input logic [15:0] t);
    cfg_start = 1;
    tick;
    cfg_start = 0;
    chk("load_busy", busy, 1);
    chk("load_ready", cfg_ready, 1);
    for (int i = 0; i < 4; i++) begin
      cfg_valid = 1; cfg_data = t[i*4 +: 4];
      tick;
      if (i < 3) chk("load_nodone", cfg_done, 0);
    end
    cfg_valid = 0;
    chk("load_done", cfg_done, 1);
    chk("load_idle", busy, 0);
    tick;
    chk("load_done_once", cfg_done, 0);
  endtask

  initial begin
    int d0;
    vt[0] = '{4'd0, 1'b1}; vt[1] = '{4'd5, 1'b1}; vt[2] = '{4'd10, 1'b1};
    vt[3] = '{4'd15, 1'b1}; vt[4] = '{4'd1, 1'b0}; vt[5] = '{4'd6, 1'b0};
    vt[6] = '{4'd14, 1'b0};
    tick;
    rst = 1;
    #3;
    rst = 0;
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_cfg_done", cfg_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_f", f, 0);
    chk("rst_in_ready", in_ready, 1);
    eval(4'd9, 1'b0, "rst_eval");
    tick;
    chk("idle_ov", out_valid, 0);
    // table 0x8421 then back-to-back evaluations
    load(16'h8421);
    for (int i = 0; i < 7; i++) begin
      x = vt[i].x; in_valid = 1;
      tick;
      chk($sformatf("tbl_ov_x%0d", vt[i].x), out_valid, 1);
      chk($sformatf("tbl_f_x%0d", vt[i].x), f, vt[i].f);
    end
    in_valid = 0;
    eval(4'd0, 1'b1, "hold_pre");
    tick;
    chk("hold_ov", out_valid, 0);
    chk("hold_f", f, 1);
`ifdef LUT_SHADOW_EN
    do_reset;
    cfg_start = 1;
    tick;
    cfg_start = 0;
    x = 4'd3; in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      chk("sh_in_ready", in_ready, 1);
      cfg_valid = 1; cfg_data = 4'hF;
      tick;
      chk("sh_ov", out_valid, 1);
      chk("sh_f_old", f, 0);
    end
    cfg_valid = 0;
    chk("sh_done", cfg_done, 1);
    tick;
    in_valid = 0;
    chk("sh_ov_new", out_valid, 1);
    chk("sh_f_new", f, 1);
`else
    cfg_start = 1;
    tick;
    cfg_start = 0;
    x = 4'd3; in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      chk("blk_in_ready", in_ready, 0);
      cfg_valid = 1; cfg_data = 4'hF;
      tick;
      chk("blk_ov", out_valid, 0);
    end
    cfg_valid = 0;
    chk("blk_done", cfg_done, 1);
    chk("blk_in_ready_run", in_ready, 1);
    tick;
    in_valid = 0;
    chk("blk_ov_first", out_valid, 1);
    chk("blk_f_new", f, 1);
`endif
    // restart mid-load, including a beat offered alongside the restart
    do_reset;
    d0 = dones;
    cfg_start = 1;
    tick;
    cfg_start = 0;
    for (int i = 0; i < 2; i++) begin
      cfg_valid = 1; cfg_data = 4'h5;
      tick;
    end
    cfg_start = 1; cfg_valid = 1; cfg_data = 4'h3;
    tick;
    cfg_start = 0;
    for (int i = 0; i < 4; i++) begin
      cfg_valid = 1; cfg_data = 4'hF;
      tick;
    end
    cfg_valid = 0;
    tick;
    chk("rs_done_count", dones - d0, 1);
    eval(4'd0, 1'b1, "rs_x0");
    eval(4'd9, 1'b1, "rs_x9");
    eval(4'd15, 1'b1, "rs_x15");
    cfg_valid = 1; cfg_data = 4'h0;
    chk("run_cfg_ready", cfg_ready, 0);
    tick;
    tick;
    cfg_valid = 0;
    chk("run_busy", busy, 0);
    eval(4'd0, 1'b1, "ign_x0");
    eval(4'd6, 1'b1, "ign_x6");
    // reset in the middle of a load
    cfg_start = 1;
    tick;
    cfg_start = 0;
    for (int i = 0; i < 2; i++) begin
      cfg_valid = 1; cfg_data = 4'hA;
      tick;
    end
    do_reset;
    chk("mr_busy", busy, 0);
    chk("mr_cfg_ready", cfg_ready, 0);
    eval(4'd0, 1'b0, "mr_x0");
    eval(4'd15, 1'b0, "mr_x15");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
